// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet decoder: validates 11-bit frames, assembles 3-byte packets,
// decodes buttons/deltas and tracks a clamped cursor position.
module ps2_mouse_packet #(
   parameter int XMAX    = 639,
   parameter int YMAX    = 479,
   parameter int POS_W   = 10,
   parameter int TIMEOUT = 2000000
) (
   input  logic               ck,
   input  logic               reset,
   input  logic               frame_valid,
   input  logic [10:0]        frame_in,
   output logic               pkt_valid,
   output logic [2:0]         buttons,
   output logic signed [8:0]  dx,
   output logic signed [8:0]  dy,
   output logic               x_ovf,
   output logic               y_ovf,
   output logic [POS_W-1:0]   x_pos,
   output logic [POS_W-1:0]   y_pos,
   output logic               frame_err,
   output logic               sync_err
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [POS_W-1:0]        X_RST    = POS_W'(XMAX / 2);
   localparam logic [POS_W-1:0]        Y_RST    = POS_W'(YMAX / 2);
   localparam logic signed [POS_W+1:0] XMAX_S   = (POS_W+2)'(XMAX);
   localparam logic signed [POS_W+1:0] YMAX_S   = (POS_W+2)'(YMAX);

   typedef enum logic [1:0] {B0, B1, B2} state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   // header byte without its always-one sync bit: {Yovf,Xovf,Ys,Xs,M,R,L}
   logic [6:0]            r_hdr;
   logic [7:0]            r_b1;
   logic                  r_pkt_valid;
   logic                  r_frame_err;
   logic                  r_sync_err;
   logic [2:0]            r_buttons;
   logic signed [8:0]     r_dx;
   logic signed [8:0]     r_dy;
   logic                  r_x_ovf;
   logic                  r_y_ovf;
   logic [POS_W-1:0]      r_x_pos;
   logic [POS_W-1:0]      r_y_pos;

   logic                  w_good;
   logic [7:0]            w_data;
   logic signed [8:0]     w_dx;
   logic signed [8:0]     w_dy;
   logic signed [POS_W+1:0] w_x_sum;
   logic signed [POS_W+1:0] w_y_sum;
   logic [POS_W-1:0]      w_x_next;
   logic [POS_W-1:0]      w_y_next;

   assign w_good = ~frame_in[0] & frame_in[10] & (^frame_in[9:1]);
   assign w_data = frame_in[8:1];

   // Deltas as they will be committed when the third byte arrives this cycle
   assign w_dx = {r_hdr[3], r_b1};
   assign w_dy = {r_hdr[4], w_data};

   // Two guard bits keep the sum free of wrap-around before clamping
   assign w_x_sum = $signed({2'b00, r_x_pos}) + $signed({{(POS_W-7){w_dx[8]}}, w_dx});
   assign w_y_sum = $signed({2'b00, r_y_pos}) - $signed({{(POS_W-7){w_dy[8]}}, w_dy});

   always_comb begin
      w_x_next = w_x_sum[POS_W-1:0];
      if (w_x_sum[POS_W+1])
         w_x_next = '0;
      else if (w_x_sum > XMAX_S)
         w_x_next = XMAX_S[POS_W-1:0];

      w_y_next = w_y_sum[POS_W-1:0];
      if (w_y_sum[POS_W+1])
         w_y_next = '0;
      else if (w_y_sum > YMAX_S)
         w_y_next = YMAX_S[POS_W-1:0];
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         r_state     <= B0;
         r_cnt       <= '0;
         r_hdr       <= '0;
         r_b1        <= '0;
         r_pkt_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_sync_err  <= 1'b0;
         r_buttons   <= '0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_x_ovf     <= 1'b0;
         r_y_ovf     <= 1'b0;
         r_x_pos     <= X_RST;
         r_y_pos     <= Y_RST;
      end else begin
         r_pkt_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_sync_err  <= 1'b0;

         if (frame_valid) begin
            // An arriving frame always wins over a simultaneous timeout expiry
            r_cnt <= '0;
            if (!w_good) begin
               r_frame_err <= 1'b1;
               r_state     <= B0;
            end else begin
               case (r_state)
                  B0: begin
                     if (w_data[3]) begin
                        r_hdr   <= {w_data[7:4], w_data[2:0]};
                        r_state <= B1;
                     end else begin
                        r_sync_err <= 1'b1;
                     end
                  end
                  B1: begin
                     r_b1    <= w_data;
                     r_state <= B2;
                  end
                  B2: begin
                     r_pkt_valid <= 1'b1;
                     r_buttons   <= r_hdr[2:0];
                     r_dx        <= w_dx;
                     r_dy        <= w_dy;
                     r_x_ovf     <= r_hdr[5];
                     r_y_ovf     <= r_hdr[6];
                     if (!r_hdr[5] && !r_hdr[6]) begin
                        r_x_pos <= w_x_next;
                        r_y_pos <= w_y_next;
                     end
                     r_state <= B0;
                  end
                  default: r_state <= B0;
               endcase
            end
         end else if (r_state == B0) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_sync_err <= 1'b1;
            r_state    <= B0;
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign pkt_valid = r_pkt_valid;
   assign frame_err = r_frame_err;
   assign sync_err  = r_sync_err;
   assign buttons   = r_buttons;
   assign dx        = r_dx;
   assign dy        = r_dy;
   assign x_ovf     = r_x_ovf;
   assign y_ovf     = r_y_ovf;
   assign x_pos     = r_x_pos;
   assign y_pos     = r_y_pos;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: directed plan steps plus random frames, checked
// against a byte-queue packet model with integer cursor arithmetic.
module tb_ps2_mouse_packet;

   localparam int XMAX    = 639;
   localparam int YMAX    = 479;
   localparam int POS_W   = 10;
   localparam int TIMEOUT = 100;

   logic              ck = 1'b0;
   logic              reset = 1'b1;
   logic              frame_valid = 1'b0;
   logic [10:0]       frame_in = '0;
   logic              pkt_valid;
   logic [2:0]        buttons;
   logic signed [8:0] dx;
   logic signed [8:0] dy;
   logic              x_ovf;
   logic              y_ovf;
   logic [POS_W-1:0]  x_pos;
   logic [POS_W-1:0]  y_pos;
   logic              frame_err;
   logic              sync_err;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state
   int q[$];
   int m_btn, m_dx, m_dy, m_xo, m_yo, m_x, m_y;
   int e_pv, e_fe, e_se;
   int m_idle;

   ps2_mouse_packet #(
      .XMAX(XMAX), .YMAX(YMAX), .POS_W(POS_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .ck(ck), .reset(reset), .frame_valid(frame_valid), .frame_in(frame_in),
      .pkt_valid(pkt_valid), .buttons(buttons), .dx(dx), .dy(dy),
      .x_ovf(x_ovf), .y_ovf(y_ovf), .x_pos(x_pos), .y_pos(y_pos),
      .frame_err(frame_err), .sync_err(sync_err)
   );

   always #5 ck = ~ck;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int sext9(input int sign, input int b);
      return sign ? b - 256 : b;
   endfunction

   task automatic model_reset();
      q.delete();
      m_btn = 0; m_dx = 0; m_dy = 0; m_xo = 0; m_yo = 0;
      m_x = XMAX / 2; m_y = YMAX / 2;
      e_pv = 0; e_fe = 0; e_se = 0; m_idle = 0;
   endtask

   task automatic model_frame(input bit good, input logic [7:0] d);
      int b0, b1, b2;
      e_pv = 0; e_fe = 0; e_se = 0; m_idle = 0;
      if (!good) begin
         e_fe = 1;
         q.delete();
      end else if (q.size() == 0 && !d[3]) begin
         e_se = 1;
      end else begin
         q.push_back(int'(d));
         if (q.size() == 3) begin
            b0 = q[0]; b1 = q[1]; b2 = q[2];
            m_btn = b0 & 7;
            m_dx  = sext9((b0 >> 4) & 1, b1);
            m_dy  = sext9((b0 >> 5) & 1, b2);
            m_xo  = (b0 >> 6) & 1;
            m_yo  = (b0 >> 7) & 1;
            if (m_xo == 0 && m_yo == 0) begin
               m_x = clamp(m_x + m_dx, XMAX);
               m_y = clamp(m_y - m_dy, YMAX);
            end
            e_pv = 1;
            q.delete();
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pkt_valid"}, int'(pkt_valid), e_pv);
      check({tag, ".frame_err"}, int'(frame_err), e_fe);
      check({tag, ".sync_err"},  int'(sync_err),  e_se);
      check({tag, ".buttons"},   int'(buttons),   m_btn);
      check({tag, ".dx"},        int'(dx),        m_dx);
      check({tag, ".dy"},        int'(dy),        m_dy);
      check({tag, ".x_ovf"},     int'(x_ovf),     m_xo);
      check({tag, ".y_ovf"},     int'(y_ovf),     m_yo);
      check({tag, ".x_pos"},     int'(x_pos),     m_x);
      check({tag, ".y_pos"},     int'(y_pos),     m_y);
   endtask

   // bad: 0 good, 1 parity flipped, 2 start high, 3 stop low
   task automatic send(input logic [7:0] d, input int bad);
      logic [10:0] f;
      f = {1'b1, ~^d, d, 1'b0};
      if (bad == 1) f[9] = ~f[9];
      if (bad == 2) f[0] = 1'b1;
      if (bad == 3) f[10] = 1'b0;
      frame_in    = f;
      frame_valid = 1'b1;
      @(posedge ck); #1;
      frame_valid = 1'b0;
      frame_in    = 11'($urandom);
      model_frame(bad == 0, d);
      check_all("frame");
      $display("frame 0x%02h bad=%0d pv=%0b fe=%0b se=%0b btn=%0d dx=%0d dy=%0d x=%0d y=%0d",
               d, bad, pkt_valid, frame_err, sync_err, buttons, dx, dy, x_pos, y_pos);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge ck); #1;
         e_pv = 0; e_fe = 0; e_se = 0;
         if (q.size() > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               e_se = 1;
               q.delete();
               m_idle = 0;
            end
         end
         check_all("idle");
      end
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send(a, 0); send(b, 0); send(c, 0);
   endtask

   task automatic pulse_reset();
      @(posedge ck); #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      $display("reset x=%0d y=%0d btn=%0d dx=%0d", x_pos, y_pos, buttons, dx);
      @(posedge ck); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int bad;

      model_reset();
      repeat (2) @(posedge ck);
      #1;
      check_all("por");
      reset = 1'b0;
      idle(2);

      // basic packet
      send3(8'h09, 8'h05, 8'h03);
      check("plan1.x", int'(x_pos), 324);
      check("plan1.y", int'(y_pos), 236);
      idle(1);

      // walk cursor to x=5 from center, then clamp at 0 and saturate at XMAX
      pulse_reset();
      send3(8'h18, 8'h01, 8'h00);
      send3(8'h18, 8'hC5, 8'h00);
      check("plan2.x5", int'(x_pos), 5);
      send3(8'h38, 8'hF6, 8'hFB);
      check("plan2.x0", int'(x_pos), 0);
      check("plan2.y244", int'(y_pos), 244);
      repeat (6) send3(8'h08, 8'h7F, 8'h00);
      check("plan2.xsat", int'(x_pos), XMAX);

      // parity error on byte 1, then recovery
      send(8'h09, 0); send(8'h05, 1);
      send3(8'h09, 8'h02, 8'h02);
      send(8'h0A, 0); send(8'h11, 2);
      send(8'h0A, 3);

      // lost sync then recovery
      send(8'h00, 0);
      send3(8'h08, 8'h01, 8'h01);
      check("plan4.dx", int'(dx), 1);
      check("plan4.dy", int'(dy), 1);

      // timeout expiry, then frames at the last moments before and at expiry
      send(8'h08, 0);
      idle(TIMEOUT + 2);
      send(8'h08, 0); idle(TIMEOUT - 2); send(8'h03, 0); send(8'h02, 0);
      send(8'h08, 0); idle(TIMEOUT - 1); send(8'hFD, 0); send(8'h04, 0);
      send(8'h09, 0); send(8'h01, 0); idle(TIMEOUT - 1); send(8'h01, 0);

      // overflow packet keeps position
      send3(8'h49, 8'h10, 8'h10);
      check("plan6.xovf", int'(x_ovf), 1);

      // reset while waiting for byte 2, then a clean packet
      send(8'h09, 0); send(8'h04, 0);
      pulse_reset();
      send3(8'h0A, 8'h07, 8'h09);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         d = 8'($urandom);
         if (q.size() == 0) begin
            if ($urandom_range(0, 9) != 0) d[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) d[7:6] = 2'b00;
         end
         bad = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
         send(d, bad);
         idle(int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
